// File: rtl/bus_pkg.sv
// Shared bus widths for the arbiter and the address decoder.
package bus_pkg;
    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 16;
endpackage

// File: rtl/bus_arbiter.sv
// Shares the decoder master port between NUM_MASTERS requesters, with a transaction watchdog.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest index wins.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_MASTERS-1:0] m_valid_i,
    input  logic [ADDR_WIDTH-1:0]  m_addr_i  [NUM_MASTERS],
    input  logic [DATA_WIDTH-1:0]  m_wdata_i [NUM_MASTERS],
    input  logic [NUM_MASTERS-1:0] m_we_i,
    output logic [NUM_MASTERS-1:0] m_ready_o,
    output logic [DATA_WIDTH-1:0]  m_rdata_o [NUM_MASTERS],
    output logic [NUM_MASTERS-1:0] m_err_o,
    output logic                   bus_valid_o,
    output logic [ADDR_WIDTH-1:0]  bus_addr_o,
    output logic [DATA_WIDTH-1:0]  bus_wdata_o,
    output logic                   bus_we_o,
    input  logic                   bus_ready_i,
    input  logic [DATA_WIDTH-1:0]  bus_rdata_i,
    input  logic                   bus_err_i,
    output logic [NUM_MASTERS-1:0] grant_o,
    output logic                   busy_o,
    output logic                   timeout_o
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [CW-1:0]          r_cnt;
    logic                   w_cnt_inc;
    logic [IW-1:0]          w_win_idx;
    logic [NUM_MASTERS-1:0] w_win_oh;
    logic [IW-1:0]          w_gidx;
    logic                   w_any_req;

    assign w_any_req = |m_valid_i;
    assign grant_o   = r_grant;
    assign busy_o    = (r_state == ST_GRANT);

`ifdef ARB_ROUND_ROBIN_EN
    logic [IW-1:0] r_ptr;

    // Round-robin pointer remembers the most recent winner.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr <= IW'(NUM_MASTERS - 1);
        end else if ((r_state == ST_IDLE) && w_any_req) begin
            r_ptr <= w_win_idx;
        end else begin
            r_ptr <= r_ptr;
        end
    end

    // Scan downward so the candidate nearest after the pointer is written last and wins.
    always_comb begin
        w_win_idx = '0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            w_win_idx = m_valid_i[(int'(r_ptr) + k) % NUM_MASTERS] ?
                        IW'((int'(r_ptr) + k) % NUM_MASTERS) : w_win_idx;
        end
    end
`else
    // Fixed priority: scanning downward leaves the lowest requesting index.
    always_comb begin
        w_win_idx = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            w_win_idx = m_valid_i[k] ? IW'(k) : w_win_idx;
        end
    end
`endif

    // One-hot form of the winner, and index form of the registered grant.
    always_comb begin
        w_win_oh            = '0;
        w_win_oh[w_win_idx] = 1'b1;
        w_gidx              = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            w_gidx = r_grant[k] ? IW'(k) : w_gidx;
        end
    end

    // State, grant and watchdog registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    r_grant <= w_any_req ? w_win_oh : '0;
                    r_cnt   <= '0;
                end
                ST_GRANT: begin
                    if (w_cnt_inc) begin
                        r_grant <= r_grant;
                        r_cnt   <= r_cnt + CW'(1);
                    end else begin
                        r_grant <= '0;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Next state plus the combinational bus and response paths.
    always_comb begin
        w_next_state = r_state;
        w_cnt_inc    = 1'b0;
        bus_valid_o  = 1'b0;
        bus_addr_o   = '0;
        bus_wdata_o  = '0;
        bus_we_o     = 1'b0;
        m_ready_o    = '0;
        m_err_o      = '0;
        timeout_o    = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            m_rdata_o[k] = '0;
        end
        case (r_state)
            ST_IDLE: begin
                w_next_state = w_any_req ? ST_GRANT : ST_IDLE;
            end
            ST_GRANT: begin
                bus_valid_o = m_valid_i[w_gidx];
                bus_addr_o  = m_addr_i[w_gidx];
                bus_wdata_o = m_wdata_i[w_gidx];
                bus_we_o    = m_we_i[w_gidx];
                // A slave response always beats a watchdog expiry in the same cycle.
                if (bus_ready_i) begin
                    m_ready_o[w_gidx] = 1'b1;
                    m_rdata_o[w_gidx] = bus_rdata_i;
                    m_err_o[w_gidx]   = bus_err_i;
                    w_next_state      = ST_IDLE;
                end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    m_ready_o[w_gidx] = 1'b1;
                    m_err_o[w_gidx]   = 1'b1;
                    timeout_o         = 1'b1;
                    w_next_state      = ST_IDLE;
                end else if (!m_valid_i[w_gidx]) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: expected responses are queued when the slave is driven.
module tb_bus_arbiter;
    import bus_pkg::*;

    localparam int NM = 2;

    typedef struct {
        int                    idx;
        logic [DATA_WIDTH-1:0] rdata;
        logic                  err;
        logic                  to;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NM-1:0]         m_valid = '0;
    logic [ADDR_WIDTH-1:0] m_addr  [NM];
    logic [DATA_WIDTH-1:0] m_wdata [NM];
    logic [NM-1:0]         m_we = '0;
    logic [NM-1:0]         m_ready;
    logic [DATA_WIDTH-1:0] m_rdata [NM];
    logic [NM-1:0]         m_err;
    logic                  bus_valid;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] bus_wdata;
    logic                  bus_we;
    logic                  bus_ready = 1'b0;
    logic [DATA_WIDTH-1:0] bus_rdata = '0;
    logic                  bus_err = 1'b0;
    logic [NM-1:0]         grant;
    logic                  busy;
    logic                  timeout;

    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];

    bus_arbiter #(.NUM_MASTERS(NM), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .m_valid_i(m_valid), .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_we_i(m_we),
        .m_ready_o(m_ready), .m_rdata_o(m_rdata), .m_err_o(m_err),
        .bus_valid_o(bus_valid), .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata),
        .bus_we_o(bus_we), .bus_ready_i(bus_ready), .bus_rdata_i(bus_rdata),
        .bus_err_i(bus_err), .grant_o(grant), .busy_o(busy), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    // Response monitor: every ready strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t          e;
        logic [NM-1:0] ev;
        if (!rst && (|m_ready)) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_ready actual=%b required=none", m_ready);
            end else begin
                e = sb_q.pop_front();
                ev = '0;
                ev[e.idx] = 1'b1;
                if (m_ready !== ev || m_rdata[e.idx] !== e.rdata || m_err !== (e.err ? ev : 2'b00)
                    || timeout !== e.to) begin
                    failures++;
                    $display("FAIL sb_response actual ready=%b rdata=%h err=%b to=%b required ready=%b rdata=%h err=%b to=%b",
                             m_ready, m_rdata[e.idx], m_err, timeout, ev, e.rdata, e.err, e.to);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int idx, input logic [DATA_WIDTH-1:0] rd, input logic er, input logic to);
        exp_t e;
        e.idx = idx; e.rdata = rd; e.err = er; e.to = to;
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        m_addr[0] = '0; m_addr[1] = '0; m_wdata[0] = '0; m_wdata[1] = '0;
        rst = 1'b1;
        tick(); tick();
        @(negedge clk);
        checks++;
        if ({grant, busy, bus_valid, m_ready, m_err, timeout} !== 9'b0) begin
            failures++;
            $display("FAIL reset_outputs actual grant=%b busy=%b bvalid=%b ready=%b err=%b to=%b required all 0",
                     grant, busy, bus_valid, m_ready, m_err, timeout);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        tick();
        m_valid[0] = 1'b1; m_addr[0] = 16'h0010; m_we[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_valid !== 1'b0) begin
            failures++; $display("FAIL single_cycle0_bvalid actual=%b required=0", bus_valid);
        end
        tick();
        bus_ready = 1'b1; bus_rdata = 16'hA5A5;
        push(0, 16'hA5A5, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (bus_valid !== 1'b1 || bus_addr !== 16'h0010 || grant !== 2'b01) begin
            failures++;
            $display("FAIL single_cycle1 actual bvalid=%b addr=%h grant=%b required 1 0010 01", bus_valid, bus_addr, grant);
        end
        tick();
        m_valid[0] = 1'b0; bus_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (grant !== 2'b00 || busy !== 1'b0) begin
            failures++; $display("FAIL single_cycle2 actual grant=%b busy=%b required 00 0", grant, busy);
        end
    endtask

    task automatic test_contention();
        int            exp_idx;
        logic [NM-1:0] exp_g;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_valid = 2'b11; m_addr[0] = 16'h0100; m_addr[1] = 16'h0200; m_we = 2'b00;
        bus_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            checks++;
            if (grant !== 2'b00) begin
                failures++; $display("FAIL contention_arb_cycle%0d actual grant=%b required 00", t, grant);
            end
            tick();
`ifdef ARB_ROUND_ROBIN_EN
            exp_idx = t % 2;
`else
            exp_idx = 0;
`endif
            exp_g = '0;
            exp_g[exp_idx] = 1'b1;
            bus_rdata = 16'h1000 + 16'(t);
            push(exp_idx, 16'h1000 + 16'(t), 1'b0, 1'b0);
            @(negedge clk);
            checks++;
            if (grant !== exp_g || bus_addr !== m_addr[exp_idx]) begin
                failures++;
                $display("FAIL contention_txn%0d actual grant=%b addr=%h required %b %h", t, grant, bus_addr, exp_g, m_addr[exp_idx]);
            end
            tick();
        end
        m_valid = 2'b00; bus_ready = 1'b0;
    endtask

    task automatic test_timeout();
        tick();
        m_valid[1] = 1'b1; m_addr[1] = 16'h0300;
        bus_rdata = 16'hDEAD;
        @(negedge clk);
        for (int g = 1; g <= 16; g++) begin
            tick();
            if (g == 16) push(1, 16'h0000, 1'b1, 1'b1);
            @(negedge clk);
            checks++;
            if (timeout !== (g == 16) || busy !== 1'b1 || grant !== 2'b10) begin
                failures++;
                $display("FAIL timeout_cycle%0d actual to=%b busy=%b grant=%b required %b 1 10", g, timeout, busy, grant, (g == 16));
            end
        end
        tick();
        m_valid[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (timeout !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL timeout_after actual to=%b busy=%b required 0 0", timeout, busy);
        end
    endtask

    task automatic test_timeout_collision();
        tick();
        m_valid[0] = 1'b1; m_addr[0] = 16'h0400;
        @(negedge clk);
        for (int g = 1; g <= 16; g++) begin
            tick();
            if (g == 16) begin
                bus_ready = 1'b1; bus_err = 1'b0; bus_rdata = 16'h5A5A;
                push(0, 16'h5A5A, 1'b0, 1'b0);
            end
            @(negedge clk);
            checks++;
            if (timeout !== 1'b0) begin
                failures++; $display("FAIL collision_cycle%0d actual to=%b required 0", g, timeout);
            end
        end
        tick();
        m_valid[0] = 1'b0; bus_ready = 1'b0;
    endtask

    task automatic test_decoder_error();
        tick();
        m_valid[1] = 1'b1; m_addr[1] = 16'hFFFF; m_we[1] = 1'b1; m_wdata[1] = 16'h1234;
        @(negedge clk);
        tick();
        bus_ready = 1'b1; bus_err = 1'b1; bus_rdata = 16'h0000;
        push(1, 16'h0000, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (bus_we !== 1'b1 || bus_wdata !== 16'h1234 || bus_addr !== 16'hFFFF) begin
            failures++;
            $display("FAIL decerr_bus actual we=%b wdata=%h addr=%h required 1 1234 ffff", bus_we, bus_wdata, bus_addr);
        end
        tick();
        m_valid[1] = 1'b0; m_we[1] = 1'b0; bus_ready = 1'b0; bus_err = 1'b0;
    endtask

    task automatic test_reset_mid();
        tick();
        m_valid[1] = 1'b1; m_addr[1] = 16'h0500;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({grant, busy, bus_valid, m_ready, m_err, timeout} !== 9'b0 || m_rdata[1] !== '0) begin
            failures++;
            $display("FAIL reset_mid actual grant=%b busy=%b bvalid=%b ready=%b err=%b to=%b required all 0",
                     grant, busy, bus_valid, m_ready, m_err, timeout);
        end
        m_valid = 2'b00;
        tick();
        tick();
        rst = 1'b0;
        m_valid = 2'b11; m_addr[0] = 16'h0600;
        @(negedge clk);
        tick();
        bus_ready = 1'b1; bus_rdata = 16'h7777;
        push(0, 16'h7777, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (grant !== 2'b01) begin
            failures++; $display("FAIL reset_mid_regrant actual grant=%b required 01", grant);
        end
        tick();
        m_valid = 2'b00; bus_ready = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_timeout();
        test_timeout_collision();
        test_decoder_error();
        test_reset_mid();
        checks++;
        if (sb_q.size() != 0) begin
            failures++; $display("FAIL sb_leftover actual=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Multi-master arbiter that shares the single master port of the address decoder between `NUM_MASTERS` requesters. It selects one requester per transaction, forwards that requester's request to the decoder, and returns the decoder's response only to the granted requester. A watchdog terminates transactions with an error response if no slave responds within a bounded number of cycles.

## Interface
- `NUM_MASTERS`, 2: requester count, 2..8.
- `TIMEOUT_CYCLES`, 16: maximum bus cycles per transaction, 2..256.
- `ADDR_WIDTH`, `DATA_WIDTH`: taken from `bus_pkg`.

- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `m_valid_i` in [NUM_MASTERS]: per-master request.
- `m_addr_i` in [ADDR_WIDTH] x NUM_MASTERS (unpacked): per-master address.
- `m_wdata_i` in [DATA_WIDTH] x NUM_MASTERS (unpacked): per-master write data.
- `m_we_i` in [NUM_MASTERS]: per-master write enable.
- `m_ready_o` out [NUM_MASTERS]: per-master completion strobe.
- `m_rdata_o` out [DATA_WIDTH] x NUM_MASTERS (unpacked): per-master read data.
- `m_err_o` out [NUM_MASTERS]: per-master error, qualified by `m_ready_o`.
- `bus_valid_o` out 1: request to the decoder.
- `bus_addr_o` out ADDR_WIDTH: address to the decoder.
- `bus_wdata_o` out DATA_WIDTH: write data to the decoder.
- `bus_we_o` out 1: write enable to the decoder.
- `bus_ready_i` in 1: decoder completion.
- `bus_rdata_i` in DATA_WIDTH: decoder read data.
- `bus_err_i` in 1: decoder error.
- `grant_o` out [NUM_MASTERS]: one-hot registered grant.
- `busy_o` out 1: high in the GRANT state.
- `timeout_o` out 1: one-cycle pulse when the watchdog fires.

## Operation
- States: IDLE and GRANT.
- IDLE:
  - If any bit of `m_valid_i` is set, select a winner, register `grant_o`, clear the watchdog counter, and go to GRANT.
  - Otherwise remain in IDLE.
- GRANT:
  - `bus_*` outputs are combinational copies of the granted master's inputs; `bus_valid_o = m_valid_i[g]`.
  - If `bus_ready_i=1`: drive `m_ready_o[g]=1`, `m_rdata_o[g]=bus_rdata_i`, `m_err_o[g]=bus_err_i` in the same cycle. Next state is IDLE and the grant is cleared.
  - Else if the counter equals `TIMEOUT_CYCLES-1`: drive `m_ready_o[g]=1`, `m_err_o[g]=1`, `m_rdata_o[g]=0`, `timeout_o=1`. Next state is IDLE.
  - Else if `m_valid_i[g]=0` (protocol violation: master withdrew): go to IDLE with no response.
  - Otherwise increment the counter, which has width `$clog2(TIMEOUT_CYCLES)`.
- Non-granted masters always see `m_ready_o=0`, `m_err_o=0`, `m_rdata_o=0`.
- Masters hold valid, addr, wdata and we stable until they receive ready.
- Reset values:
  - State IDLE, `grant_o=0`, counter 0.
  - `busy_o=0`, `timeout_o=0`, `bus_valid_o=0`.
  - All `m_ready_o`/`m_err_o` 0; all data outputs 0.
  - Round-robin pointer set to `NUM_MASTERS-1`.
- Reset asserted mid-transaction abandons the transaction immediately. No response is issued.

## Timing
- A request seen in IDLE in cycle N produces a registered grant and `bus_valid_o` in cycle N+1. A zero-wait slave completes the transaction in N+1.
- Each transaction occupies at least 2 cycles: one arbitration cycle plus one or more GRANT cycles. Back-to-back transactions from one master therefore have a 1-cycle gap.
- The watchdog fires in the `TIMEOUT_CYCLES`-th GRANT cycle.
- If `bus_ready_i` arrives in the same cycle as the timeout, `bus_ready_i` wins: the slave response is passed through and `timeout_o=0`.
- The decoder reports an invalid address with `ready=1, err=1` in the same cycle. This passes through to the master as-is.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - Round-robin arbitration. The search starts at (last granted index + 1) mod `NUM_MASTERS`.
  - The pointer updates to the winner on each IDLE→GRANT transition.
- Undefined:
  - Fixed priority; the lowest index wins.
  - The pointer logic is absent.

## Test plan
- **Single master read.** M0 requests read of 0x0010, slave ready next cycle with rdata=0xA5A5. Required: `bus_valid_o` in cycle 1, `m_ready_o[0]=1` and `m_rdata_o[0]=0xA5A5` in cycle 1, `grant_o=0` in cycle 2.
- **Contention.** M0 and M1 both assert valid continuously for 4 transactions.
  - With `ARB_ROUND_ROBIN_EN`: grant order M0, M1, M0, M1.
  - Without it: M0, M0, M0, M0 while M1 is starved.
- **Timeout.** `TIMEOUT_CYCLES=16` and the slave never responds. Required: in the 16th GRANT cycle, `m_ready_o[g]=1`, `m_err_o[g]=1`, rdata 0, `timeout_o` pulses for one cycle, then IDLE.
- **Timeout collision.** `bus_ready_i` arrives exactly in the 16th GRANT cycle with `bus_err_i=0`. Required: `m_err_o=0`, `timeout_o=0`.
- **Decoder error.** Address 0xFFFF returns ready=1, err=1. Required: the granted master sees `m_err_o=1` in the same cycle.
- **Reset mid-transaction.** Assert `rst_i` during the 3rd GRANT cycle. Required: all outputs 0 immediately; the next request is granted to M0 first.
